// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: opcodes, driver states and datapath widths shared by the tiny ALU driver.
package tinyalu_pkg;
  localparam int OPERAND_W = 8;
  localparam int RESULT_W = 16;
  typedef enum logic [2:0] {
    NOP = 3'b000,
    ADD = 3'b001,
    AND = 3'b010,
    XOR = 3'b011,
    MUL = 3'b100
  } opcode_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} drv_state_t;
endpackage

// File: rtl/tinyalu_driver.sv
// tinyalu_driver: valid/ready command-to-ALU start/done initiator with post-completion drain.
// Optional abort of stalled commands with TINYALU_DRIVER_TIMEOUT_EN.
module tinyalu_driver
  import tinyalu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPERAND_W-1:0] cmd_a,
  input  logic [OPERAND_W-1:0] cmd_b,
  input  logic [2:0]           cmd_op,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [RESULT_W-1:0]  alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RESULT_W-1:0]  rsp_result,
  output logic [2:0]           rsp_op,
  output logic                 rsp_error
);
  // one counter serves both the ISSUE timeout and the post-completion drain
  localparam int CMAX = DRAIN_CYCLES > TIMEOUT_CYCLES ? DRAIN_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
`ifdef TINYALU_DRIVER_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT_CYCLES);
`else
  assign rsp_error = 1'b0;
`endif
  drv_state_t state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      cnt        <= '0;
`ifdef TINYALU_DRIVER_TIMEOUT_EN
      rsp_error  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!cmd_ready) cmd_ready <= 1'b1;
          else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_op    <= cmd_op;
            cnt       <= '0;
`ifdef TINYALU_DRIVER_TIMEOUT_EN
            rsp_error <= 1'b0;
`endif
            if (cmd_op == NOP) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_op     <= cmd_op;
            end else begin
              state     <= ISSUE;
              alu_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (alu_done) begin
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_op     <= alu_op;
            cnt        <= DRAIN_LD;
            state      <= RESP;
          end
`ifdef TINYALU_DRIVER_TIMEOUT_EN
          else if (cnt == TO_LD) begin
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_op     <= alu_op;
            rsp_error  <= 1'b1;
            cnt        <= DRAIN_LD;
            state      <= RESP;
          end else cnt <= cnt + ONE;
`endif
        end
        RESP: begin
          if (cnt != '0) cnt <= cnt - ONE;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (cnt == '0) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end else state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt <= ONE) begin
            cnt       <= '0;
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end else cnt <= cnt - ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tinyalu_driver.sv
// tb_tinyalu_driver: drives the driver against a behavioural tiny ALU with a response scoreboard.
module tb_tinyalu_driver;
  import tinyalu_pkg::*;
  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, alu_start, alu_done, rsp_valid, rsp_ready, rsp_error;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b;
  logic [2:0] cmd_op, alu_op, rsp_op;
  logic [15:0] alu_result, rsp_result;
  logic alu_rst_n, done_raw, kill_done;
  logic [1:0] mcnt;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [15:0] r;
    logic [2:0] op;
    logic e;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tinyalu_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_error(rsp_error)
  );

  function automatic logic [15:0] exp_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op == 3'b000) return 16'h0;
    if (op == 3'b001) return 16'(a) + 16'(b);
    if (op == 3'b010) return {8'h0, a & b};
    if (op == 3'b011) return {8'h0, a ^ b};
    return 16'(a) * 16'(b);
  endfunction

  // tiny ALU: single-cycle ops raise done one edge after start, MUL four edges after
  assign alu_rst_n = ~reset;
  assign alu_done = done_raw & ~kill_done;
  always @(posedge clk) begin
    if (!alu_rst_n) begin
      done_raw <= 1'b0;
      mcnt <= 2'd0;
      alu_result <= 16'h0;
    end else begin
      done_raw <= 1'b0;
      if (!alu_start) mcnt <= 2'd0;
      else if (!done_raw) begin
        if (alu_op[2]) begin
          if (mcnt == 2'd3) begin
            done_raw <= 1'b1;
            alu_result <= exp_res(alu_op, alu_a, alu_b);
            mcnt <= 2'd0;
          end else mcnt <= mcnt + 2'd1;
        end else if (alu_op != 3'b000) begin
          done_raw <= 1'b1;
          alu_result <= exp_res(alu_op, alu_a, alu_b);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.r);
        chk("rsp_op", rsp_op, e.op);
        chk("rsp_error", rsp_error, e.e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick;
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic err);
    sb.push_back('{r: err ? 16'h0 : exp_res(op, a, b), op: op, e: err});
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic err);
    wait_ready;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    push(op, a, b, err);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic settle(input logic rnd);
    int n = 0;
    while ((sb.size() != 0 || rsp_valid || !cmd_ready) && n < 80) begin
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    rsp_ready = 1'b1;
    chk("settle", sb.size() == 0 && cmd_ready, 1);
  endtask

  initial begin
    logic [15:0] h_res;
    logic [2:0] h_op;
    logic stable, rdy_low;
    int t_cap, t_start2;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1; kill_done = 1'b0;
    cmd_a = 8'h0; cmd_b = 8'h0; cmd_op = 3'b000;
    repeat (3) tick;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_error", rsp_error, 0);
    reset = 1'b0;
    tick;
    chk("rdy_after_rst", cmd_ready, 1);
    // ADD FF+01
    issue(ADD, 8'hFF, 8'h01, 1'b0);
    chk("add_start_c0", alu_start, 1);
    tick;
    chk("add_valid_c1", rsp_valid, 0);
    tick;
    chk("add_valid_c2", rsp_valid, 1);
    chk("add_result_c2", rsp_result, 16'h0100);
    repeat (3) tick;
    chk("add_rdy_c5", cmd_ready, 0);
    tick;
    chk("add_rdy_c6", cmd_ready, 1);
    // MUL FF*FF
    issue(MUL, 8'hFF, 8'hFF, 1'b0);
    repeat (4) tick;
    chk("mul_start_c4", alu_start, 1);
    chk("mul_valid_c4", rsp_valid, 0);
    tick;
    chk("mul_start_c5", alu_start, 0);
    chk("mul_valid_c5", rsp_valid, 1);
    chk("mul_result_c5", rsp_result, 16'hFE01);
    settle(1'b0);
    // back-to-back XOR then AND with cmd_valid held
    wait_ready;
    cmd_valid = 1'b1; cmd_op = XOR; cmd_a = 8'hAA; cmd_b = 8'h0F;
    push(XOR, 8'hAA, 8'h0F, 1'b0);
    tick;
    cmd_op = AND;
    push(AND, 8'hAA, 8'h0F, 1'b0);
    t_cap = -1; t_start2 = -1;
    for (int c = 1; c < 30; c++) begin
      tick;
      if (t_cap < 0 && rsp_valid) t_cap = c;
      if (t_cap >= 0 && t_start2 < 0 && alu_start) begin
        t_start2 = c;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_capture", t_cap, 2);
    chk("b2b_gap", t_start2 - t_cap, 5);
    settle(1'b0);
    // NOP never starts the ALU
    rsp_ready = 1'b0;
    issue(NOP, 8'h12, 8'h34, 1'b0);
    tick;
    chk("nop_valid_c1", rsp_valid, 1);
    chk("nop_result_c1", rsp_result, 0);
    chk("nop_start_c1", alu_start, 0);
    rsp_ready = 1'b1;
    settle(1'b0);
    // response held under back-pressure
    rsp_ready = 1'b0;
    issue(ADD, 8'h10, 8'h20, 1'b0);
    repeat (2) tick;
    h_res = rsp_result; h_op = rsp_op;
    stable = rsp_valid; rdy_low = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      stable &= rsp_valid && rsp_result == h_res && rsp_op == h_op;
      rdy_low &= !cmd_ready;
    end
    chk("hold_stable", stable, 1);
    chk("hold_result", h_res, 16'h0030);
    chk("hold_rdy_low", rdy_low, 1);
    rsp_ready = 1'b1;
    tick;
    chk("hold_rdy_after", cmd_ready, 1);
    chk("hold_valid_after", rsp_valid, 0);
`ifdef TINYALU_DRIVER_TIMEOUT_EN
    kill_done = 1'b1;
    rsp_ready = 1'b0;
    issue(ADD, 8'h01, 8'h02, 1'b1);
    repeat (16) tick;
    chk("to_valid_c16", rsp_valid, 0);
    tick;
    chk("to_valid_c17", rsp_valid, 1);
    chk("to_error_c17", rsp_error, 1);
    chk("to_start_c17", alu_start, 0);
    rsp_ready = 1'b1;
    settle(1'b0);
    kill_done = 1'b0;
`endif
    // reset in the middle of a MUL
    issue(MUL, 8'h05, 8'h07, 1'b0);
    repeat (3) tick;
    reset = 1'b1;
    sb.delete();
    tick;
    chk("mrst_start", alu_start, 0);
    chk("mrst_valid", rsp_valid, 0);
    chk("mrst_ready", cmd_ready, 0);
    chk("mrst_alu_op", alu_op, 0);
    reset = 1'b0;
    repeat (8) tick;
    chk("mrst_no_rsp", rsp_valid, 0);
    chk("mrst_idle", cmd_ready, 1);
    // random commands with random back-pressure
    for (int i = 0; i < 10; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
      settle(1'b1);
    end
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
